// File: rtl/ysyx_22050078_rf_wb_arb.sv
// rtl/ysyx_22050078_rf_wb_arb.sv - regfile write-port round-robin arbiter and RAW scoreboard
// Optional operand forwarding from the registered write stage: YSYX_22050078_RF_WB_BYPASS_EN
module ysyx_22050078_rf_wb_arb #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_flush,
   input  logic                      i_iss_valid,
   input  logic [ADDR_WIDTH-1:0]     i_iss_rd,
   input  logic [ADDR_WIDTH-1:0]     i_rs1_addr,
   input  logic [ADDR_WIDTH-1:0]     i_rs2_addr,
   output logic                      o_rs1_busy,
   output logic                      o_rs2_busy,
`ifdef YSYX_22050078_RF_WB_BYPASS_EN
   input  logic [DATA_WIDTH-1:0]     i_rs1_rdata,
   input  logic [DATA_WIDTH-1:0]     i_rs2_rdata,
   output logic [DATA_WIDTH-1:0]     o_rs1_fwd,
   output logic [DATA_WIDTH-1:0]     o_rs2_fwd,
`endif
   input  logic                      i_req0_valid,
   input  logic [ADDR_WIDTH-1:0]     i_req0_addr,
   input  logic [DATA_WIDTH-1:0]     i_req0_data,
   output logic                      o_req0_ready,
   input  logic                      i_req1_valid,
   input  logic [ADDR_WIDTH-1:0]     i_req1_addr,
   input  logic [DATA_WIDTH-1:0]     i_req1_data,
   output logic                      o_req1_ready,
   output logic                      o_wen,
   output logic [ADDR_WIDTH-1:0]     o_waddr,
   output logic [DATA_WIDTH-1:0]     o_wdata,
   output logic [(1<<ADDR_WIDTH)-1:0] o_busy_mask
);

   localparam int NREG = 1 << ADDR_WIDTH;

   // x0 is never tracked, so the stored mask starts at bit 1
   logic [NREG-1:1]       busy;
   logic [NREG-1:1]       busy_next;
   logic [NREG-1:1]       set_mask;
   logic [NREG-1:1]       clr_mask;
   logic                  rr;
   logic                  grant0;
   logic                  grant1;
   logic                  xfer;
   logic                  real_write;
   logic [ADDR_WIDTH-1:0] xfer_addr;
   logic [DATA_WIDTH-1:0] xfer_data;
   logic                  rs1_pending;
   logic                  rs2_pending;

   assign o_busy_mask = {busy, 1'b0};

   // rr=0 gives req0 priority on contention, rr=1 gives req1 priority
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst && !i_flush) begin
         if (i_req0_valid && (!i_req1_valid || !rr))
            grant0 = 1'b1;
         else if (i_req1_valid)
            grant1 = 1'b1;
      end
   end

   assign o_req0_ready = grant0;
   assign o_req1_ready = grant1;
   assign xfer         = grant0 | grant1;
   assign xfer_addr    = grant0 ? i_req0_addr : i_req1_addr;
   assign xfer_data    = grant0 ? i_req0_data : i_req1_data;
   assign real_write   = xfer && (xfer_addr != '0);

   // applying set after clear lets a same-cycle newer producer keep the reg busy
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      for (int n = 1; n < NREG; n++) begin
         set_mask[n] = i_iss_valid && (i_iss_rd == ADDR_WIDTH'(n));
         clr_mask[n] = xfer && (xfer_addr == ADDR_WIDTH'(n));
      end
      busy_next = (busy & ~clr_mask) | set_mask;
   end

   assign rs1_pending = o_busy_mask[i_rs1_addr];
   assign rs2_pending = o_busy_mask[i_rs2_addr];

`ifdef YSYX_22050078_RF_WB_BYPASS_EN
   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit    = o_wen && (o_waddr == i_rs1_addr) && (i_rs1_addr != '0);
   assign rs2_hit    = o_wen && (o_waddr == i_rs2_addr) && (i_rs2_addr != '0);
   assign o_rs1_fwd  = rs1_hit ? o_wdata : i_rs1_rdata;
   assign o_rs2_fwd  = rs2_hit ? o_wdata : i_rs2_rdata;
   assign o_rs1_busy = rs1_pending && !rs1_hit;
   assign o_rs2_busy = rs2_pending && !rs2_hit;
`else
   assign o_rs1_busy = rs1_pending;
   assign o_rs2_busy = rs2_pending;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         o_wen   <= 1'b0;
         o_waddr <= '0;
         o_wdata <= '0;
         busy    <= '0;
         rr      <= 1'b0;
      end else begin
         o_wen <= real_write;
         // x0 writes are swallowed, so the visible address/data keep the last real write
         if (real_write) begin
            o_waddr <= xfer_addr;
            o_wdata <= xfer_data;
         end
         if (xfer)
            rr <= grant0;
         busy <= i_flush ? '0 : busy_next;
      end
   end

endmodule
